// File: rtl/dpram_arb_pkg.sv
// Shared constants for the two-requester port-B arbiter of the dual-port block RAM.
package dpram_arb_pkg;

    localparam int LOCK_CNT_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_st_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. While a lock is held, only the lock owner can be granted.
module rr_arb2
    import dpram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       locked,
    input  logic       owner,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_owner;

    always_comb begin
        gnt    = 2'b00;
        gnt_id = REQ0;
        if (!rst) begin
            if (locked) begin
                if (req[owner]) begin
                    gnt_id      = owner;
                    gnt[owner]  = 1'b1;
                end
            end else if (req[0] && req[1]) begin
                // On contention, the requester that did not win last time gets the port.
                gnt_id      = (last_owner == REQ0) ? REQ1 : REQ0;
                gnt[gnt_id] = 1'b1;
            end else if (req[0]) begin
                gnt_id = REQ0;
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt_id = REQ1;
                gnt[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= REQ1;
        end else if (|gnt) begin
            last_owner <= gnt_id;
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares RAM port B between requesters R0 and R1: round-robin per access, optional burst lock,
// with a registered read-return path that tags each read with its requester.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 13,
    parameter int LOCK_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX_C = LOCK_CNT_W'(LOCK_MAX);

    logic [1:0]            gnt;
    logic                  gnt_id;
    logic                  any_gnt;
    lock_st_e              lock_st;
    logic                  lock_owner;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic [LOCK_CNT_W-1:0] lock_cnt_inc;
    logic                  sel_we;
    logic                  sel_lock;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  owner_req;
    logic                  owner_lock;
    logic [ADDR_W-1:0]     addr_hold;

    logic                  vld_p0;
    logic                  id_p0;
    logic [1:0]            rvalid_p1;
    logic [DATA_W-1:0]     rdata0_p1;
    logic [DATA_W-1:0]     rdata1_p1;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({r1_req, r0_req}),
        .locked (lock_st == LOCKED),
        .owner  (lock_owner),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign any_gnt      = |gnt;
    assign sel_we       = (gnt_id == REQ1) ? r1_we    : r0_we;
    assign sel_lock     = (gnt_id == REQ1) ? r1_lock  : r0_lock;
    assign sel_addr     = (gnt_id == REQ1) ? r1_addr  : r0_addr;
    assign sel_wdata    = (gnt_id == REQ1) ? r1_wdata : r0_wdata;
    assign owner_req    = (lock_owner == REQ1) ? r1_req  : r0_req;
    assign owner_lock   = (lock_owner == REQ1) ? r1_lock : r0_lock;
    assign lock_cnt_inc = lock_cnt + 1'b1;

    assign r0_gnt    = gnt[0];
    assign r1_gnt    = gnt[1];
    assign ram_we    = any_gnt & sel_we;
    // Holding the last address keeps the RAM's registered read output stable when idle.
    assign ram_addr  = any_gnt ? sel_addr  : addr_hold;
    assign ram_wdata = any_gnt ? sel_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_st    <= UNLOCKED;
            lock_owner <= REQ0;
            lock_cnt   <= '0;
            addr_hold  <= '0;
        end else begin
            if (any_gnt) begin
                addr_hold <= sel_addr;
            end
            if (lock_st == UNLOCKED) begin
                // A limit of one grant means the lock expires as soon as it is taken.
                if (any_gnt && sel_lock && (LOCK_MAX_C > 8'd1)) begin
                    lock_st    <= LOCKED;
                    lock_owner <= gnt_id;
                    lock_cnt   <= 8'd1;
                end
            end else if (any_gnt) begin
                if (!sel_lock || (lock_cnt_inc >= LOCK_MAX_C)) begin
                    lock_st  <= UNLOCKED;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt_inc;
                end
            end else if (!owner_req && !owner_lock) begin
                lock_st  <= UNLOCKED;
                lock_cnt <= '0;
            end
        end
    end

    // Stage p0: read tag captured on the grant edge, RAM registers the address
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            id_p0  <= REQ0;
        end else begin
            vld_p0 <= any_gnt & ~sel_we;
            id_p0  <= gnt_id;
        end
    end

    // Stage p1: RAM data captured into the tagged requester's return register
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_p1 <= 2'b00;
            rdata0_p1 <= '0;
            rdata1_p1 <= '0;
        end else begin
            rvalid_p1[0] <= vld_p0 & (id_p0 == REQ0);
            rvalid_p1[1] <= vld_p0 & (id_p0 == REQ1);
            if (vld_p0 && (id_p0 == REQ0)) begin
                rdata0_p1 <= ram_rdata;
            end
            if (vld_p0 && (id_p0 == REQ1)) begin
                rdata1_p1 <= ram_rdata;
            end
        end
    end

    assign r0_rvalid = rvalid_p1[0];
    assign r1_rvalid = rvalid_p1[1];
    assign r0_rdata  = rdata0_p1;
    assign r1_rdata  = rdata1_p1;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a port-B RAM model and a read-return scoreboard.
module tb_dpram_port_arbiter;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 13;
    localparam int LOCK_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              r0_req, r0_we, r0_lock;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt, r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;
    logic              r1_req, r1_we, r1_lock;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt, r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    always #5 clk = ~clk;

    dpram_port_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_lock   (r0_lock),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_lock   (r1_lock),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM port B: synchronous write, registered read address; unwritten words hold a fixed pattern
    logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
    bit                wr_flag [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] addr_q;
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return {3'b000, a} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr]     <= pre_data;
            wr_flag[pre_addr] <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            wr_flag[ram_addr] <= 1'b1;
        end
        addr_q <= ram_addr;
    end

    assign ram_rdata = wr_flag[addr_q] ? mem[addr_q] : init_word(addr_q);

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t              sbq [$];
    logic [DATA_W-1:0] ref_mem [int];
    int                compared   = 0;
    int                mismatched = 0;
    int                cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic book_grant(input logic id, input logic we, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] wd, input string tag);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'(a));
        check({tag, "_ram_we"}, 32'(ram_we), 32'(we));
        if (we) ref_mem[int'(a)] = wd;
        else    sbq.push_back('{id, ref_rd(a), cyc + 2});
    endtask

    task automatic chk(input logic eg0, input logic eg1, input string tag);
        @(negedge clk);
        check({tag, "_g0"}, 32'(r0_gnt), 32'(eg0));
        check({tag, "_g1"}, 32'(r1_gnt), 32'(eg1));
        if (eg0) book_grant(1'b0, r0_we, r0_addr, r0_wdata, tag);
        if (eg1) book_grant(1'b1, r1_we, r1_addr, r1_wdata, tag);
        if (!eg0 && !eg1) check({tag, "_ram_we_idle"}, 32'(ram_we), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},    32'({r1_gnt, r0_gnt}), 32'd0);
        check({tag, "_rvalid"}, 32'({r1_rvalid, r0_rvalid}), 32'd0);
        check({tag, "_r0data"}, 32'(r0_rdata), 32'd0);
        check({tag, "_r1data"}, 32'(r1_rdata), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    // Read returns are matched in order against the scoreboard, including exact latency.
    always @(negedge clk) begin
        exp_t e;
        if (r0_rvalid || r1_rvalid) begin
            if (sbq.size() == 0) begin
                check("rv_unexpected", 32'({r1_rvalid, r0_rvalid}), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("rv_single", 32'(r0_rvalid & r1_rvalid), 32'd0);
                check("rv_id", 32'(r1_rvalid), 32'(e.id));
                check("rv_data", 32'(e.id ? r1_rdata : r0_rdata), 32'(e.data));
                check("rv_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int k0, k1;
        rst = 1'b1;
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
        pre_en = 1'b1; pre_addr = '0; pre_data = 16'hBEEF;
        ref_mem[0] = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        pre_en = 1'b0;
        @(negedge clk);
        check_idle("reset");
        tick;
        rst = 1'b0;

        // Test 1: write then read back on R0
        r0_req = 1; r0_we = 1; r0_addr = 13'h005; r0_wdata = 16'h1234;
        chk(1, 0, "t1_wr");
        tick; r0_we = 0;
        chk(1, 0, "t1_rd");
        tick; r0_req = 0;
        chk(0, 0, "t1_wait1");
        tick;
        chk(0, 0, "t1_wait2");
        check("t1_r0_rvalid", 32'(r0_rvalid), 32'd1);
        check("t1_r0_rdata", 32'(r0_rdata), 32'h1234);
        check("t1_r1_rvalid", 32'(r1_rvalid), 32'd0);

        // Test 2: both read every cycle; R0 won last, so R1 goes first
        k0 = 0; k1 = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            r0_req = 1; r0_we = 0; r0_addr = 13'h100 + 13'(k0);
            r1_req = 1; r1_we = 0; r1_addr = 13'h200 + 13'(k1);
            chk(i % 2 == 1, i % 2 == 0, "t2_alt");
            if (i % 2 == 0) k1++;
            else            k0++;
        end
        tick; r0_req = 0; r1_req = 0;
        chk(0, 0, "t2_idle");

        // Test 3: R1 locked burst limited to LOCK_MAX grants
        tick; r1_req = 1; r1_lock = 1; r1_we = 0; r1_addr = 13'h300;
        chk(0, 1, "t3_first");
        for (int i = 0; i < 3; i++) begin
            tick; r0_req = 1; r0_we = 0; r0_addr = 13'h301;
            chk(0, 1, "t3_locked");
        end
        tick;
        chk(1, 0, "t3_forced_release");
        tick; r0_req = 0;
        chk(0, 1, "t3_relock");
        tick; r1_req = 0; r1_lock = 0;
        chk(0, 0, "t3_drop");

        // Test 4: idle owner keeps the lock until it drops lock
        tick; r0_req = 1; r0_lock = 1; r0_we = 0; r0_addr = 13'h400;
        chk(1, 0, "t4_lock");
        for (int i = 0; i < 3; i++) begin
            tick; r0_req = 0; r1_req = 1; r1_we = 0; r1_addr = 13'h401;
            chk(0, 0, "t4_idle_locked");
        end
        tick; r0_lock = 0;
        chk(0, 0, "t4_release");
        tick;
        chk(0, 1, "t4_r1_gnt");
        tick; r1_req = 0;
        chk(0, 0, "t4_idle");

        // Test 6: preloaded word, then read-after-write through the other requester
        tick; r1_req = 1; r1_we = 0; r1_addr = 13'h000;
        chk(0, 1, "t6_rd1");
        tick; r1_req = 0; r0_req = 1; r0_we = 1; r0_addr = 13'h000; r0_wdata = 16'hCAFE;
        chk(1, 0, "t6_wr");
        tick; r0_req = 0; r0_we = 0; r1_req = 1;
        chk(0, 1, "t6_rd2");
        check("t6_rv1", 32'(r1_rvalid), 32'd1);
        check("t6_data1", 32'(r1_rdata), 32'hBEEF);
        tick; r1_req = 0;
        chk(0, 0, "t6_wait");
        tick;
        chk(0, 0, "t6_ret2");
        check("t6_rv2", 32'(r1_rvalid), 32'd1);
        check("t6_data2", 32'(r1_rdata), 32'hCAFE);
        tick;
        chk(0, 0, "t6_hold");
        check("t6_hold_rv", 32'(r1_rvalid), 32'd0);
        check("t6_hold_data", 32'(r1_rdata), 32'hCAFE);

        // Test 5: reset with a read in flight drops it and restores arbitration state
        tick; r0_req = 1; r0_we = 0; r0_addr = 13'h500;
        chk(1, 0, "t5_rd");
        tick; r0_req = 0; rst = 1; sbq.delete();
        chk(0, 0, "t5_rst_on");
        tick;
        chk(0, 0, "t5_rst_edge");
        check_idle("t5_after_rst");
        tick; rst = 0;
        chk(0, 0, "t5_rst_off");
        tick; r0_req = 1; r1_req = 1; r0_we = 0; r1_we = 0;
        r0_addr = 13'h501; r1_addr = 13'h502;
        chk(1, 0, "t5_first_after_rst");
        tick; r0_req = 0;
        chk(0, 1, "t5_second_after_rst");
        tick; r1_req = 0;
        chk(0, 0, "t5_idle");

        for (int i = 0; i < 10 && sbq.size() != 0; i++) tick;
        check("drain_empty", 32'(sbq.size()), 32'd0);
        repeat (4) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
